// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: parametrised IEEE-754 binary square root, one root bit per cycle.
//
// Restoring digit recurrence over MAN_W+2 root bits (hidden, fraction, guard) with
// subnormal normalisation and special-case bypass. Operations do not overlap.
//
// Parameters:
//   EXP_W  exponent width (bias = 2^(EXP_W-1)-1)
//   MAN_W  stored mantissa width
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data     operand handshake; in_ready is high only when idle
//   out_valid/out_ready/out_data  result handshake; result held until accepted
//   is_nan, is_pinf, is_ninf      result class flags (is_ninf is never asserted)
//   is_inexact                    result is not exact (guard | sticky)
// Build option:
//   FP_SQRT_RNE_EN  defined: round to nearest even; undefined: truncate.

module fp_sqrt_iter #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   is_nan,
  output logic                   is_pinf,
  output logic                   is_ninf,
  output logic                   is_inexact
);

  localparam int unsigned W   = EXP_W + MAN_W + 1;
  localparam int unsigned SW  = MAN_W + 2;           // significand and root width
  localparam int unsigned XW  = 2 * SW;              // radicand width
  localparam int unsigned RW  = MAN_W + 5;           // partial remainder width
  localparam int unsigned CW  = $clog2(MAN_W + 3);   // iteration counter width
  localparam int unsigned LZW = $clog2(MAN_W + 1);
  localparam int unsigned EW  = EXP_W + LZW + 2;     // signed unbiased exponent width

  localparam logic [EW-1:0] Bias = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0]  QNan = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StUnpack, StCalc, StRound, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    op_q, op_d;
  logic [XW-1:0]   x_q, x_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [SW-1:0]   root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0] rexp_q, rexp_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            nan_q, nan_d, pinf_q, pinf_d, inexact_q, inexact_d;

  // Leading-zero count of the stored fraction; MAN_W when all zero.
  function automatic logic [LZW-1:0] lzc(input logic [MAN_W-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (v[i]) n = LZW'(MAN_W - 1 - i);
    end
    return n;
  endfunction

  // Operand classification
  logic             op_sign;
  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_frac;
  logic             exp_max, exp_zero, frac_zero;
  logic             in_nan, in_inf, in_zero;

  assign op_sign   = op_q[W-1];
  assign op_exp    = op_q[W-2:MAN_W];
  assign op_frac   = op_q[MAN_W-1:0];
  assign exp_max   = &op_exp;
  assign exp_zero  = (op_exp == '0);
  assign frac_zero = (op_frac == '0);
  assign in_nan    = exp_max & ~frac_zero;
  assign in_inf    = exp_max & frac_zero;
  assign in_zero   = exp_zero & frac_zero;

  // Normalisation: significand carries the hidden 1 at bit MAN_W, then is made to
  // pair with an even exponent so the root exponent is exactly e/2.
  logic [LZW-1:0] sub_shift;
  logic [SW-1:0]  sig_norm, sig_adj;
  logic [EW-1:0]  e_unb, e_adj, e_half;

  always_comb begin
    sub_shift = lzc(op_frac) + LZW'(1);
    if (exp_zero) begin
      sig_norm = {2'b00, op_frac} << sub_shift;
      e_unb    = EW'(1) - Bias - EW'(sub_shift);
    end else begin
      sig_norm = {2'b01, op_frac};
      e_unb    = EW'(op_exp) - Bias;
    end
    if (e_unb[0]) begin
      sig_adj = sig_norm << 1;
      e_adj   = e_unb - EW'(1);
    end else begin
      sig_adj = sig_norm;
      e_adj   = e_unb;
    end
    e_half = $signed(e_adj) >>> 1;
  end

  // One restoring recurrence step: bring down two radicand bits, try (2q)*2+1.
  logic [RW-1:0] rem_sh, trial;
  logic          take;

  assign rem_sh = {rem_q[RW-3:0], x_q[XW-1:XW-2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign take   = (rem_sh >= trial);

  // Rounding
  logic guard, sticky, inc;

  assign guard  = root_q[0];
  assign sticky = (rem_q != '0);
`ifdef FP_SQRT_RNE_EN
  assign inc = guard & (sticky | root_q[1]);
`else
  assign inc = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    rexp_d     = rexp_q;
    out_data_d = out_data_q;
    nan_d      = nan_q;
    pinf_d     = pinf_q;
    inexact_d  = inexact_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_data;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        if (in_nan || (op_sign && !in_zero)) begin
          out_data_d = QNan;
          nan_d      = 1'b1;
          pinf_d     = 1'b0;
          inexact_d  = 1'b0;
          state_d    = StDone;
        end else if (in_inf) begin
          out_data_d = op_q;
          nan_d      = 1'b0;
          pinf_d     = 1'b1;
          inexact_d  = 1'b0;
          state_d    = StDone;
        end else if (in_zero) begin
          out_data_d = op_q;
          nan_d      = 1'b0;
          pinf_d     = 1'b0;
          inexact_d  = 1'b0;
          state_d    = StDone;
        end else begin
          x_d     = {sig_adj, {SW{1'b0}}};
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          rexp_d  = EXP_W'(e_half + Bias);
          state_d = StCalc;
        end
      end
      StCalc: begin
        x_d    = x_q << 2;
        rem_d  = take ? (rem_sh - trial) : rem_sh;
        root_d = {root_q[SW-2:0], take};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(SW - 1)) state_d = StRound;
      end
      StRound: begin
        // Whole-word increment lets a fraction carry-out bump the exponent.
        out_data_d = {1'b0, rexp_q, root_q[MAN_W:1]} + W'(inc);
        nan_d      = 1'b0;
        pinf_d     = 1'b0;
        inexact_d  = guard | sticky;
        cnt_d      = '0;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      x_q        <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      rexp_q     <= '0;
      out_data_q <= '0;
      nan_q      <= 1'b0;
      pinf_q     <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      rexp_q     <= rexp_d;
      out_data_q <= out_data_d;
      nan_q      <= nan_d;
      pinf_q     <= pinf_d;
      inexact_q  <= inexact_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_data   = out_data_q;
  assign is_nan     = nan_q;
  assign is_pinf    = pinf_q;
  assign is_ninf    = 1'b0;
  assign is_inexact = inexact_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Testbench for fp_sqrt_iter: fp16 and fp32 instances, scoreboard of expected results.
module tb_fp_sqrt_iter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fp16 instance signals
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic        h_nan, h_pinf, h_ninf, h_inexact;
  logic [15:0] h_in_data, h_out_data;

  // fp32 instance signals
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic        s_nan, s_pinf, s_ninf, s_inexact;
  logic [31:0] s_in_data, s_out_data;

  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (h_in_valid),
    .in_ready   (h_in_ready),
    .in_data    (h_in_data),
    .out_valid  (h_out_valid),
    .out_ready  (h_out_ready),
    .out_data   (h_out_data),
    .is_nan     (h_nan),
    .is_pinf    (h_pinf),
    .is_ninf    (h_ninf),
    .is_inexact (h_inexact)
  );

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_data    (s_in_data),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_data   (s_out_data),
    .is_nan     (s_nan),
    .is_pinf    (s_pinf),
    .is_ninf    (s_ninf),
    .is_inexact (s_inexact)
  );

  // flags packed as {nan, pinf, ninf, inexact}
  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t tab[$];
  int   total;
  int   bad;

  localparam logic [3:0] FNone = 4'b0000;
  localparam logic [3:0] FNan  = 4'b1000;
  localparam logic [3:0] FPinf = 4'b0100;
  localparam logic [3:0] FInex = 4'b0001;

  function automatic void add_vec(input logic [31:0] din, input logic [31:0] dout,
                                  input logic [3:0] fl, input int lat);
    vec_t v;
    v.din  = din;
    v.dout = dout;
    v.fl   = fl;
    v.lat  = lat;
    tab.push_back(v);
  endfunction

  // Drivers: called #1 after a rising edge with the DUT idle; return #1 after the
  // handshake edge. They only collect what the DUT produced.
  task automatic xact_h(input logic [15:0] d, output logic [15:0] od,
                        output logic [3:0] fl, output int lat);
    h_in_valid = 1'b1;
    h_in_data  = d;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    od = h_out_data;
    fl = {h_nan, h_pinf, h_ninf, h_inexact};
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
  endtask

  task automatic xact_s(input logic [31:0] d, output logic [31:0] od,
                        output logic [3:0] fl, output int lat);
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    od = s_out_data;
    fl = {s_nan, s_pinf, s_ninf, s_inexact};
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (h_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b/%b want=1/1", h_in_ready, s_in_ready);
    end
    total++;
    if (h_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b/%b want=0/0", h_out_valid, s_out_valid);
    end
    total++;
    if (h_out_data !== 16'h0000 || s_out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_out_data got=%h/%h want=0/0", h_out_data, s_out_data);
    end
    total++;
    if ({h_nan, h_pinf, h_ninf, h_inexact, s_nan, s_pinf, s_ninf, s_inexact} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags got=%b%b%b%b/%b%b%b%b want=0", h_nan, h_pinf, h_ninf,
               h_inexact, s_nan, s_pinf, s_ninf, s_inexact);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (h_in_ready !== 1'b1 || h_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want=1/0", h_in_ready,
               h_out_valid);
    end
  endtask

  task automatic test_fp16_vectors();
    logic [15:0] od;
    logic [3:0]  fl;
    int          lat;
    vec_t        e;
    tab.delete();
`ifdef FP_SQRT_RNE_EN
    add_vec(32'h4200, 32'h3EEE, FInex, 14);
    add_vec(32'h03FF, 32'h1FFF, FInex, 14);
`else
    add_vec(32'h4200, 32'h3EED, FInex, 14);
    add_vec(32'h03FF, 32'h1FFE, FInex, 14);
`endif
    add_vec(32'h7C00, 32'h7C00, FPinf, 1);
    add_vec(32'hFC00, 32'hFE00, FNan,  1);
    add_vec(32'hBC00, 32'hFE00, FNan,  1);
    add_vec(32'h7D00, 32'hFE00, FNan,  1);
    add_vec(32'h8000, 32'h8000, FNone, 1);
    add_vec(32'h0000, 32'h0000, FNone, 1);
    add_vec(32'h0001, 32'h0C00, FNone, 14);
    add_vec(32'h7BFF, 32'h5BFF, FInex, 14);
    add_vec(32'h4400, 32'h4000, FNone, 14);
    add_vec(32'h3C00, 32'h3C00, FNone, 14);
    foreach (tab[i]) begin
      sb_q.push_back(tab[i]);
      xact_h(tab[i].din[15:0], od, fl, lat);
      e = sb_q.pop_front();
      total++;
      if (od !== e.dout[15:0]) begin
        bad++;
        $display("FAIL fp16_data in=%h got=%h want=%h", e.din[15:0], od, e.dout[15:0]);
      end
      total++;
      if (fl !== e.fl) begin
        bad++;
        $display("FAIL fp16_flags in=%h got=%b want=%b", e.din[15:0], fl, e.fl);
      end
      total++;
      if (lat != e.lat) begin
        bad++;
        $display("FAIL fp16_latency in=%h got=%0d want=%0d", e.din[15:0], lat, e.lat);
      end
    end
  endtask

  task automatic test_fp32_vectors();
    logic [31:0] od;
    logic [3:0]  fl;
    int          lat;
    vec_t        e;
    tab.delete();
    add_vec(32'h40800000, 32'h40000000, FNone, 27);
    add_vec(32'h00000001, 32'h1A3504F3, FInex, 27);
    add_vec(32'hFF800000, 32'hFFC00000, FNan,  1);
    add_vec(32'h7F800000, 32'h7F800000, FPinf, 1);
    foreach (tab[i]) begin
      sb_q.push_back(tab[i]);
      xact_s(tab[i].din, od, fl, lat);
      e = sb_q.pop_front();
      total++;
      if (od !== e.dout) begin
        bad++;
        $display("FAIL fp32_data in=%h got=%h want=%h", e.din, od, e.dout);
      end
      total++;
      if (fl !== e.fl) begin
        bad++;
        $display("FAIL fp32_flags in=%h got=%b want=%b", e.din, fl, e.fl);
      end
      total++;
      if (lat != e.lat) begin
        bad++;
        $display("FAIL fp32_latency in=%h got=%0d want=%0d", e.din, lat, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t e;
    vec_t v;
    int   lat;
    v.din = 32'h4400; v.dout = 32'h4000; v.fl = FNone; v.lat = 14;
    sb_q.push_back(v);
    h_in_valid = 1'b1;
    h_in_data  = 16'h4400;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    total++;
    if (h_out_valid !== 1'b1 || h_out_data !== e.dout[15:0]) begin
      bad++;
      $display("FAIL bp_first got valid=%b data=%h want valid=1 data=%h", h_out_valid,
               h_out_data, e.dout[15:0]);
    end
    // Next operand is offered while the result is stalled.
    v.din = 32'h7C00; v.dout = 32'h7C00; v.fl = FPinf; v.lat = 1;
    sb_q.push_back(v);
    h_in_valid = 1'b1;
    h_in_data  = 16'h7C00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (h_out_data !== e.dout[15:0] || h_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%h want valid=1 data=%h", c,
                 h_out_valid, h_out_data, e.dout[15:0]);
      end
      total++;
      if (h_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_in_ready cycle=%0d got=%b want=0", c, h_in_ready);
      end
    end
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
    total++;
    if (h_out_valid !== 1'b0 || h_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_handshake got valid=%b in_ready=%b want 0/1", h_out_valid, h_in_ready);
    end
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    total++;
    if (h_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept got in_ready=%b want=0", h_in_ready);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    total++;
    if (h_out_valid !== 1'b1 || h_out_data !== e.dout[15:0] || h_pinf !== 1'b1) begin
      bad++;
      $display("FAIL bp_second got valid=%b data=%h pinf=%b want valid=1 data=%h pinf=1",
               h_out_valid, h_out_data, h_pinf, e.dout[15:0]);
    end
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
  endtask

  task automatic test_reset_midcalc();
    vec_t        v;
    vec_t        e;
    int          seen;
    int          lat;
    logic [15:0] od;
    logic [3:0]  fl;
    v.din = 32'h4200;
`ifdef FP_SQRT_RNE_EN
    v.dout = 32'h3EEE;
`else
    v.dout = 32'h3EED;
`endif
    v.fl = FInex; v.lat = 14;
    sb_q.push_back(v);
    h_in_valid = 1'b1;
    h_in_data  = 16'h4200;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    // k+1 unpack, k+2..k+6 are the first five CALC edges.
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (h_out_valid !== 1'b0 || h_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_ctrl got valid=%b in_ready=%b want 0/1", h_out_valid, h_in_ready);
    end
    total++;
    if (h_out_data !== 16'h0000 || {h_nan, h_pinf, h_ninf, h_inexact} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_data got data=%h flags=%b%b%b%b want 0000/0", h_out_data, h_nan,
               h_pinf, h_ninf, h_inexact);
    end
    sb_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (h_out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_mid_no_output got=%0d valid cycles want=0", seen);
    end
    sb_q.push_back(v);
    xact_h(16'h4200, od, fl, lat);
    e = sb_q.pop_front();
    total++;
    if (od !== e.dout[15:0] || fl !== e.fl || lat != e.lat) begin
      bad++;
      $display("FAIL rst_mid_recover got data=%h flags=%b lat=%0d want data=%h flags=%b lat=%0d",
               od, fl, lat, e.dout[15:0], e.fl, e.lat);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    h_in_valid  = 1'b0;
    h_in_data   = '0;
    h_out_ready = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    test_reset();
    test_fp16_vectors();
    test_fp32_vectors();
    test_backpressure();
    test_reset_midcalc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
